// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare branch predictor: 2-bit counter
// encodings, the default index width and the saturating counter update.
package gshare_predictor_pkg;

  localparam int N_BITS_DEFAULT = 7;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_state_e;

  // Move a 2-bit counter one step toward the observed outcome, pinning at the ends.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] next_cnt;
    next_cnt = cnt;
    if (taken) begin
      if (cnt != ST) next_cnt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) next_cnt = cnt - 2'd1;
    end
    return next_cnt;
  endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch-side predict port and execute-side train port of the gshare predictor.
// master = fetch/resolve logic driving queries and updates, slave = predictor.
interface gshare_predictor_if
  import gshare_predictor_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEFAULT
);

  logic              predict_valid;
  logic [N_BITS-1:0] predict_pc;
  logic              predict_taken;
  logic [N_BITS-1:0] predict_history;

  logic              train_valid;
  logic              train_taken;
  logic              train_mispredicted;
  logic [N_BITS-1:0] train_history;
  logic [N_BITS-1:0] train_pc;

  modport master (
    output predict_valid, predict_pc,
    output train_valid, train_taken, train_mispredicted, train_history, train_pc,
    input  predict_taken, predict_history
  );

  modport slave (
    input  predict_valid, predict_pc,
    input  train_valid, train_taken, train_mispredicted, train_history, train_pc,
    output predict_taken, predict_history
  );

endinterface

// File: rtl/gshare_predictor_sat_counter_table.sv
// Pattern history table: 2**IDX_W two-bit saturating counters with one
// asynchronous read port (returns the counter MSB, i.e. the predicted
// direction) and one synchronous training write port.
module sat_counter_table
  import gshare_predictor_pkg::*;
#(
  parameter int         IDX_W    = N_BITS_DEFAULT,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [1:0] mem [DEPTH];

  // Reads see the pre-edge contents, so a same-cycle write is visible next cycle.
  assign rd_taken = mem[rd_idx][1];

  // Reset every counter to its initial bias; otherwise train the addressed entry.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= CNT_INIT;
    end else if (wr_en) begin
      mem[wr_idx] <= sat_update(mem[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare branch predictor: the global history register is XORed with the
// branch PC to index a table of 2-bit counters. Predictions are answered
// combinationally; training and misprediction recovery come from execute.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int         N_BITS   = N_BITS_DEFAULT,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic                clk,
  input  logic                areset_n,
  gshare_predictor_if.slave   bus
);

  logic [N_BITS-1:0] ghr;
  logic [N_BITS-1:0] pidx;
  logic [N_BITS-1:0] tidx;
  logic              pred_taken;
  logic              recover;

  assign pidx    = bus.predict_pc ^ ghr;
  assign tidx    = bus.train_pc ^ bus.train_history;
  assign recover = bus.train_valid & bus.train_mispredicted;

  assign bus.predict_taken   = pred_taken;
  assign bus.predict_history = ghr;

  sat_counter_table #(
    .IDX_W    (N_BITS),
    .CNT_INIT (CNT_INIT)
  ) u_pht (
    .clk      (clk),
    .areset_n (areset_n),
    .rd_idx   (pidx),
    .rd_taken (pred_taken),
    .wr_en    (bus.train_valid),
    .wr_idx   (tidx),
    .wr_taken (bus.train_taken)
  );

  // Recovery rebuilds history from the checkpoint, else speculative shift-in of each prediction.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      ghr <= '0;
    end else if (recover) begin
      ghr <= {bus.train_history[N_BITS-2:0], bus.train_taken};
    end else if (bus.predict_valid) begin
      ghr <= {ghr[N_BITS-2:0], pred_taken};
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed vectors with
// hand-computed expectations followed by a random run against a model.
module tb_gshare_predictor;

  localparam int NB = 7;

  logic clk = 1'b0;
  logic areset_n;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [1:0] phtM [128];
  logic [6:0] ghrM;

  always #5 clk = ~clk;

  gshare_predictor_if #(.N_BITS(NB)) bus ();

  gshare_predictor #(
    .N_BITS   (NB),
    .CNT_INIT (2'b01)
  ) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [6:0] ppc,
                               input logic tv, input logic tt, input logic tm,
                               input logic [6:0] th, input logic [6:0] tpc);
    bus.predict_valid      = pv;
    bus.predict_pc         = ppc;
    bus.train_valid        = tv;
    bus.train_taken        = tt;
    bus.train_mispredicted = tm;
    bus.train_history      = th;
    bus.train_pc           = tpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic expTakenUp   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic expTakenDown [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    areset_n = 1'b0;
    applyStimulus(0, 7'd0, 0, 0, 0, 7'd0, 7'd0);
    tick();
    tick();
    areset_n = 1'b1;
    tick();

    // Load GHR and PHT[0x2A] via recovery so reset has something to clear
    applyStimulus(0, 7'd0, 1, 1, 1, 7'h2A, 7'h00);
    tick();
    applyStimulus(0, 7'h00, 0, 0, 0, 7'd0, 7'd0);
    checkOutput("pre_reset_hist", 32'(bus.predict_history), 32'h55);

    // Asynchronous reset mid-cycle with no clock edge
    areset_n = 1'b0;
    #1;
    checkOutput("rst_hist_async", 32'(bus.predict_history), 32'h0);
    applyStimulus(0, 7'h00, 0, 0, 0, 7'd0, 7'd0);
    checkOutput("rst_taken_pc00", 32'(bus.predict_taken), 32'h0);
    applyStimulus(0, 7'h2A, 0, 0, 0, 7'd0, 7'd0);
    checkOutput("rst_taken_pc2A", 32'(bus.predict_taken), 32'h0);

    // Edges during reset must not update anything
    applyStimulus(1, 7'h03, 1, 1, 1, 7'h2A, 7'h03);
    tick();
    tick();
    applyStimulus(0, 7'h29, 0, 0, 0, 7'd0, 7'd0);
    checkOutput("rst_hold_hist", 32'(bus.predict_history), 32'h0);
    checkOutput("rst_hold_taken", 32'(bus.predict_taken), 32'h0);
    areset_n = 1'b1;
    tick();

    // Every entry reads weakly not-taken after release
    for (int i = 0; i < 128; i++) begin
      applyStimulus(0, 7'(i), 0, 0, 0, 7'd0, 7'd0);
      checkOutput($sformatf("init_entry_%0d", i), 32'(bus.predict_taken), 32'h0);
    end
    checkOutput("init_hist", 32'(bus.predict_history), 32'h0);

    // Saturating up: counter 1 -> 2 -> 3 -> 3 -> 3
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 7'd5, 1, 1, 0, 7'd0, 7'd5);
      checkOutput($sformatf("sat_up_%0d", i), 32'(bus.predict_taken), 32'(expTakenUp[i]));
      tick();
    end
    // Saturating down: 3 -> 2 -> 1 -> 0 -> 0
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 7'd5, 1, 0, 0, 7'd0, 7'd5);
      checkOutput($sformatf("sat_down_%0d", i), 32'(bus.predict_taken), 32'(expTakenDown[i]));
      tick();
    end
    applyStimulus(0, 7'd5, 0, 0, 0, 7'd0, 7'd0);
    checkOutput("sat_down_final", 32'(bus.predict_taken), 32'h0);
    checkOutput("train_no_ghr", 32'(bus.predict_history), 32'h0);
    // One taken from 0 should only reach 1 (no wrap from 0 down to 3)
    applyStimulus(0, 7'd5, 1, 1, 0, 7'd0, 7'd5);
    tick();
    applyStimulus(0, 7'd5, 0, 0, 0, 7'd0, 7'd0);
    checkOutput("no_wrap_low", 32'(bus.predict_taken), 32'h0);

    // History shift with not-taken predictions keeps GHR at zero
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 7'd0, 0, 0, 0, 7'd0, 7'd0);
      checkOutput($sformatf("shift_nt_hist_%0d", i), 32'(bus.predict_history), 32'h0);
      tick();
    end
    // Train PHT[0] up to strongly taken
    applyStimulus(0, 7'd0, 1, 1, 0, 7'd0, 7'd0);
    tick();
    tick();
    applyStimulus(1, 7'd0, 0, 0, 0, 7'd0, 7'd0);
    checkOutput("shift_t_taken", 32'(bus.predict_taken), 32'h1);
    checkOutput("shift_t_hist_old", 32'(bus.predict_history), 32'h0);
    tick();
    applyStimulus(1, 7'd0, 0, 0, 0, 7'd0, 7'd0);
    checkOutput("shift_t_hist_new", 32'(bus.predict_history), 32'h01);
    checkOutput("shift_idx1_taken", 32'(bus.predict_taken), 32'h0);
    tick();
    applyStimulus(0, 7'd0, 0, 0, 0, 7'd0, 7'd0);
    checkOutput("shift_hist_02", 32'(bus.predict_history), 32'h02);

    // Recovery wins over a concurrent predict shift
    applyStimulus(1, 7'd0, 1, 1, 1, 7'h2A, 7'h00);
    tick();
    applyStimulus(0, 7'd0, 0, 0, 0, 7'd0, 7'd0);
    checkOutput("recover_hist", 32'(bus.predict_history), 32'h55);
    // Mispredicted flag without train_valid is ignored
    applyStimulus(0, 7'd0, 0, 1, 1, 7'h11, 7'h00);
    tick();
    applyStimulus(0, 7'd0, 0, 0, 0, 7'd0, 7'd0);
    checkOutput("mispred_no_valid", 32'(bus.predict_history), 32'h55);
    // Correct-prediction training leaves GHR alone
    applyStimulus(0, 7'd0, 1, 0, 0, 7'h11, 7'h00);
    tick();
    applyStimulus(0, 7'd0, 0, 0, 0, 7'd0, 7'd0);
    checkOutput("train_keep_hist", 32'(bus.predict_history), 32'h55);

    // Read-before-write on the same index
    areset_n = 1'b0;
    tick();
    areset_n = 1'b1;
    tick();
    applyStimulus(0, 7'd3, 1, 1, 0, 7'd0, 7'd3);
    checkOutput("rbw_same_cycle", 32'(bus.predict_taken), 32'h0);
    tick();
    applyStimulus(0, 7'd3, 0, 0, 0, 7'd0, 7'd0);
    checkOutput("rbw_next_cycle", 32'(bus.predict_taken), 32'h1);

    // Random run against a behavioural model from a clean reset
    areset_n = 1'b0;
    tick();
    areset_n = 1'b1;
    tick();
    ghrM = '0;
    for (int i = 0; i < 128; i++) phtM[i] = 2'b01;
    for (int n = 0; n < 2000; n++) begin
      logic       pv, tv, tt, tm, expTaken;
      logic [6:0] ppc, th, tpc, pi, ti;
      int         v;
      pv  = 1'($urandom_range(0, 1));
      tv  = 1'($urandom_range(0, 1));
      tt  = 1'($urandom_range(0, 1));
      tm  = 1'($urandom_range(0, 3) == 0);
      ppc = 7'($urandom_range(0, 127));
      th  = 7'($urandom_range(0, 127));
      tpc = 7'($urandom_range(0, 127));
      applyStimulus(pv, ppc, tv, tt, tm, th, tpc);
      pi       = ppc ^ ghrM;
      expTaken = phtM[pi][1];
      checkOutput("rnd_taken", 32'(bus.predict_taken), 32'(expTaken));
      checkOutput("rnd_hist", 32'(bus.predict_history), 32'(ghrM));
      if (tv) begin
        ti = tpc ^ th;
        v  = int'(phtM[ti]) + (tt ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        phtM[ti] = 2'(v);
      end
      if (tv && tm) ghrM = {th[5:0], tt};
      else if (pv)  ghrM = {ghrM[5:0], expTaken};
      tick();
    end

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
